// File: rtl/uart_rx_os16_if.sv
// Receive-side UART bundle: serial line and parity controls in, recovered word and status out.
interface uart_rx_os16_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  rx;
    logic                  parity_en;
    logic                  odd_r_even_parity;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  done;
    logic                  parity_error;
    logic                  framing_error;
    logic                  busy;

    modport master (
        output rx, parity_en, odd_r_even_parity,
        input  data_out, done, parity_error, framing_error, busy
    );

    modport slave (
        input  rx, parity_en, odd_r_even_parity,
        output data_out, done, parity_error, framing_error, busy
    );
endinterface

// File: rtl/uart_rx_os16.sv
// 16x-oversampling UART receiver: start validation, LSB-first data, optional parity, stop check.
// Define UART_RX_MAJORITY_EN to decide each bit by 2-of-3 vote over samples 6, 7 and 8.
module uart_rx_os16 #(
    parameter int SYS_CLK    = 40000000,
    parameter int BAUD_RATE  = 9600,
    parameter int DATA_WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    uart_rx_os16_if.slave rx_if
);
    localparam int DIV_RAW = SYS_CLK / (BAUD_RATE * 16);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int TW      = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                state_reg;
    logic [TW-1:0]         tcnt_reg;
    logic [3:0]            sc_reg;
    logic [1:0]            sync_reg;
    logic                  rxs_prev_reg;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [3:0]            bit_cnt_reg;
    logic                  par_en_reg;
    logic                  par_odd_reg;
    logic                  par_flag_reg;
    logic [DATA_WIDTH-1:0] data_out_reg;
    logic                  done_reg;
    logic                  parity_error_reg;
    logic                  framing_error_reg;
    logic                  busy_reg;

    logic rxs;
    logic tick;
    logic mid;
    logic bit_val;

    assign rxs  = sync_reg[1];
    assign tick = (tcnt_reg == TW'(DIV - 1));
    // The tick that advances sc to 8 is the decision point of every bit.
    assign mid  = tick && (sc_reg == 4'd7);

`ifdef UART_RX_MAJORITY_EN
    logic s6_reg;
    logic s7_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            s6_reg <= 1'b1;
            s7_reg <= 1'b1;
        end else if (tick) begin
            if (sc_reg == 4'd5) s6_reg <= rxs;
            if (sc_reg == 4'd6) s7_reg <= rxs;
        end
    end

    assign bit_val = (s6_reg & s7_reg) | (s6_reg & rxs) | (s7_reg & rxs);
`else
    assign bit_val = rxs;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg         <= IDLE;
            tcnt_reg          <= '0;
            sc_reg            <= '0;
            sync_reg          <= 2'b11;
            rxs_prev_reg      <= 1'b1;
            shift_reg         <= '0;
            bit_cnt_reg       <= '0;
            par_en_reg        <= 1'b0;
            par_odd_reg       <= 1'b0;
            par_flag_reg      <= 1'b0;
            data_out_reg      <= '0;
            done_reg          <= 1'b0;
            parity_error_reg  <= 1'b0;
            framing_error_reg <= 1'b0;
            busy_reg          <= 1'b0;
        end else begin
            sync_reg     <= {sync_reg[0], rx_if.rx};
            rxs_prev_reg <= rxs;
            done_reg     <= 1'b0;
            tcnt_reg     <= tick ? '0 : tcnt_reg + TW'(1);
            if (tick) sc_reg <= sc_reg + 4'd1;

            case (state_reg)
                IDLE: begin
                    // Edge-triggered arming: a line held low never re-arms.
                    if (rxs_prev_reg && !rxs) begin
                        tcnt_reg  <= '0;
                        sc_reg    <= '0;
                        busy_reg  <= 1'b1;
                        state_reg <= START;
                    end
                end
                START: begin
                    if (mid) begin
                        if (!bit_val) begin
                            bit_cnt_reg  <= '0;
                            par_en_reg   <= rx_if.parity_en;
                            par_odd_reg  <= rx_if.odd_r_even_parity;
                            par_flag_reg <= 1'b0;
                            state_reg    <= DATA;
                        end else begin
                            busy_reg  <= 1'b0;
                            state_reg <= IDLE;
                        end
                    end
                end
                DATA: begin
                    if (mid) begin
                        shift_reg <= {bit_val, shift_reg[DATA_WIDTH-1:1]};
                        if (bit_cnt_reg == 4'(DATA_WIDTH - 1))
                            state_reg <= par_en_reg ? PARITY : STOP;
                        else
                            bit_cnt_reg <= bit_cnt_reg + 4'd1;
                    end
                end
                PARITY: begin
                    if (mid) begin
                        par_flag_reg <= (bit_val != ((^shift_reg) ^ par_odd_reg));
                        state_reg    <= STOP;
                    end
                end
                STOP: begin
                    if (mid) begin
                        data_out_reg      <= shift_reg;
                        parity_error_reg  <= par_en_reg & par_flag_reg;
                        framing_error_reg <= ~bit_val;
                        done_reg          <= 1'b1;
                        busy_reg          <= 1'b0;
                        state_reg         <= IDLE;
                    end
                end
                default: begin
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign rx_if.data_out      = data_out_reg;
    assign rx_if.done          = done_reg;
    assign rx_if.parity_error  = parity_error_reg;
    assign rx_if.framing_error = framing_error_reg;
    assign rx_if.busy          = busy_reg;
endmodule

// File: tb/tb_uart_rx_os16.sv
// Self-checking bench for uart_rx_os16 at DIV=1: directed frames plus randomized frames vs a frame-level model.
module tb_uart_rx_os16;
    localparam int SYS_CLK  = 1600000;
    localparam int BAUD     = 100000;
    localparam int DW       = 8;
    localparam int BIT_CLKS = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    int          done_cyc_q[$];
    logic [DW-1:0] data_q[$];
    logic        pe_q[$];
    logic        fe_q[$];
    logic        busy_after_q[$];
    bit          grab_busy = 1'b0;

    uart_rx_os16_if #(.DATA_WIDTH(DW)) dut_if();

    uart_rx_os16 #(
        .SYS_CLK   (SYS_CLK),
        .BAUD_RATE (BAUD),
        .DATA_WIDTH(DW)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .rx_if(dut_if)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Capture every done strobe and the busy level one cycle later.
    always @(posedge clk) begin
        #1;
        if (grab_busy) busy_after_q.push_back(dut_if.busy);
        grab_busy = dut_if.done;
        if (dut_if.done) begin
            done_cyc_q.push_back(cyc);
            data_q.push_back(dut_if.data_out);
            pe_q.push_back(dut_if.parity_error);
            fe_q.push_back(dut_if.framing_error);
        end
    end

    task automatic clear_q();
        done_cyc_q.delete();
        data_q.delete();
        pe_q.delete();
        fe_q.delete();
        busy_after_q.delete();
    endtask

    task automatic drive_bit(input logic b);
        dut_if.rx = b;
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    // Called at a negedge; leaves rx at the stop value.
    task automatic send_frame(input logic [DW-1:0] d, input logic pen, input logic odd,
                              input logic flip, input logic stop, input bit twiddle,
                              output int start_cyc);
        logic pbit;
        pbit = ((($countones(d) % 2) == 1) ? 1'b1 : 1'b0) ^ odd ^ flip;
        dut_if.parity_en         = pen;
        dut_if.odd_r_even_parity = odd;
        start_cyc = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < DW; i++) begin
            if (twiddle && i == 2) begin
                dut_if.parity_en         = 1'($urandom_range(0, 1));
                dut_if.odd_r_even_parity = 1'($urandom_range(0, 1));
            end
            drive_bit(d[i]);
        end
        if (pen) drive_bit(pbit);
        drive_bit(stop);
        $display("frame sent data=%02h pen=%0d odd=%0d flip=%0d stop=%0d", d, pen, odd, flip, stop);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        dut_if.rx = 1'b1;
        dut_if.parity_en = 1'b0;
        dut_if.odd_r_even_parity = 1'b0;
        repeat (5) @(negedge clk);
        n_checks++; if (dut_if.data_out !== '0) $display("FAIL reset_data_out got=%02h want=00", dut_if.data_out); else n_pass++;
        n_checks++; if (dut_if.done !== 1'b0) $display("FAIL reset_done got=%0b want=0", dut_if.done); else n_pass++;
        n_checks++; if (dut_if.parity_error !== 1'b0) $display("FAIL reset_parity_error got=%0b want=0", dut_if.parity_error); else n_pass++;
        n_checks++; if (dut_if.framing_error !== 1'b0) $display("FAIL reset_framing_error got=%0b want=0", dut_if.framing_error); else n_pass++;
        n_checks++; if (dut_if.busy !== 1'b0) $display("FAIL reset_busy got=%0b want=0", dut_if.busy); else n_pass++;
        rst = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_8n1();
        int s;
        clear_q();
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, s);
        repeat (20) @(negedge clk);
        n_checks++; if (done_cyc_q.size() != 1) $display("FAIL 8n1_done_count got=%0d want=1", done_cyc_q.size()); else n_pass++;
        if (done_cyc_q.size() >= 1) begin
            n_checks++; if (done_cyc_q[0] - s != 155) $display("FAIL 8n1_latency got=%0d want=155", done_cyc_q[0] - s); else n_pass++;
            n_checks++; if (data_q[0] !== 8'hA5) $display("FAIL 8n1_data got=%02h want=a5", data_q[0]); else n_pass++;
            n_checks++; if (pe_q[0] !== 1'b0) $display("FAIL 8n1_parity_error got=%0b want=0", pe_q[0]); else n_pass++;
            n_checks++; if (fe_q[0] !== 1'b0) $display("FAIL 8n1_framing_error got=%0b want=0", fe_q[0]); else n_pass++;
        end
        if (busy_after_q.size() >= 1) begin
            n_checks++; if (busy_after_q[0] !== 1'b0) $display("FAIL 8n1_busy_after_done got=%0b want=0", busy_after_q[0]); else n_pass++;
        end
    endtask

    task automatic test_parity();
        int s;
        for (int k = 0; k < 2; k++) begin
            clear_q();
            send_frame(8'h5A, 1'b1, 1'b0, 1'(k), 1'b1, 1'b0, s);
            repeat (20) @(negedge clk);
            n_checks++; if (done_cyc_q.size() != 1) $display("FAIL parity%0d_done_count got=%0d want=1", k, done_cyc_q.size()); else n_pass++;
            if (done_cyc_q.size() >= 1) begin
                n_checks++; if (done_cyc_q[0] - s != 171) $display("FAIL parity%0d_latency got=%0d want=171", k, done_cyc_q[0] - s); else n_pass++;
                n_checks++; if (data_q[0] !== 8'h5A) $display("FAIL parity%0d_data got=%02h want=5a", k, data_q[0]); else n_pass++;
                n_checks++; if (pe_q[0] !== 1'(k)) $display("FAIL parity%0d_parity_error got=%0b want=%0d", k, pe_q[0], k); else n_pass++;
                n_checks++; if (fe_q[0] !== 1'b0) $display("FAIL parity%0d_framing_error got=%0b want=0", k, fe_q[0]); else n_pass++;
            end
        end
    endtask

    task automatic test_framing();
        int s;
        clear_q();
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, s);
        repeat (300) @(negedge clk);
        dut_if.rx = 1'b1;
        repeat (20) @(negedge clk);
        n_checks++; if (done_cyc_q.size() != 1) $display("FAIL framing_done_count got=%0d want=1", done_cyc_q.size()); else n_pass++;
        if (done_cyc_q.size() >= 1) begin
            n_checks++; if (fe_q[0] !== 1'b1) $display("FAIL framing_error_flag got=%0b want=1", fe_q[0]); else n_pass++;
            n_checks++; if (data_q[0] !== 8'h3C) $display("FAIL framing_data got=%02h want=3c", data_q[0]); else n_pass++;
        end
    endtask

    task automatic test_false_start();
        logic [DW-1:0] prev;
        bit busy_seen;
        clear_q();
        prev = dut_if.data_out;
        busy_seen = 1'b0;
        dut_if.rx = 1'b0;
        repeat (4) @(negedge clk);
        dut_if.rx = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (dut_if.busy) busy_seen = 1'b1;
        end
        @(negedge clk);
        $display("false start glitch busy_seen=%0d", busy_seen);
        n_checks++; if (busy_seen !== 1'b1) $display("FAIL false_start_busy got=%0b want=1", busy_seen); else n_pass++;
        n_checks++; if (done_cyc_q.size() != 0) $display("FAIL false_start_done_count got=%0d want=0", done_cyc_q.size()); else n_pass++;
        n_checks++; if (dut_if.data_out !== prev) $display("FAIL false_start_data got=%02h want=%02h", dut_if.data_out, prev); else n_pass++;
        n_checks++; if (dut_if.busy !== 1'b0) $display("FAIL false_start_busy_end got=%0b want=0", dut_if.busy); else n_pass++;
    endtask

    // One-clock glitch landing on sample 7 of data bit 1; sample 8 and the vote must both survive it.
    task automatic test_glitch();
        logic [DW-1:0] d;
        d = 8'hA5;
        clear_q();
        dut_if.parity_en = 1'b0;
        drive_bit(1'b0);
        for (int i = 0; i < DW; i++) begin
            if (i == 1) begin
                dut_if.rx = d[i];
                repeat (7) @(negedge clk);
                dut_if.rx = ~d[i];
                @(negedge clk);
                dut_if.rx = d[i];
                repeat (8) @(negedge clk);
            end else begin
                drive_bit(d[i]);
            end
        end
        drive_bit(1'b1);
        repeat (20) @(negedge clk);
        $display("glitch frame data=%02h", d);
        n_checks++; if (done_cyc_q.size() != 1) $display("FAIL glitch_done_count got=%0d want=1", done_cyc_q.size()); else n_pass++;
        if (done_cyc_q.size() >= 1) begin
            n_checks++; if (data_q[0] !== 8'hA5) $display("FAIL glitch_data got=%02h want=a5", data_q[0]); else n_pass++;
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 10; n++) begin
            logic [DW-1:0] d;
            logic pen, odd, flip, stop;
            int s, gap;
            d    = DW'($urandom);
            pen  = 1'($urandom_range(0, 1));
            odd  = 1'($urandom_range(0, 1));
            flip = 1'($urandom_range(0, 1));
            stop = ($urandom_range(0, 3) != 0);
            gap  = $urandom_range(1, 20);
            clear_q();
            send_frame(d, pen, odd, flip, stop, 1'b1, s);
            dut_if.rx = 1'b1;
            repeat (gap + 20) @(negedge clk);
            n_checks++; if (done_cyc_q.size() != 1) $display("FAIL rand%0d_done_count got=%0d want=1", n, done_cyc_q.size()); else n_pass++;
            if (done_cyc_q.size() >= 1) begin
                n_checks++; if (done_cyc_q[0] - s != 155 + 16 * int'(pen)) $display("FAIL rand%0d_latency got=%0d want=%0d", n, done_cyc_q[0] - s, 155 + 16 * int'(pen)); else n_pass++;
                n_checks++; if (data_q[0] !== d) $display("FAIL rand%0d_data got=%02h want=%02h", n, data_q[0], d); else n_pass++;
                n_checks++; if (pe_q[0] !== (pen & flip)) $display("FAIL rand%0d_parity_error got=%0b want=%0b", n, pe_q[0], pen & flip); else n_pass++;
                n_checks++; if (fe_q[0] !== ~stop) $display("FAIL rand%0d_framing_error got=%0b want=%0b", n, fe_q[0], ~stop); else n_pass++;
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] d;
        int s;
        d = 8'hC3;
        clear_q();
        dut_if.parity_en = 1'b0;
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(d[i]);
        dut_if.rx = d[3];
        repeat (8) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        $display("reset asserted during data bit 3");
        n_checks++; if (dut_if.data_out !== '0) $display("FAIL rstmid_data_out got=%02h want=00", dut_if.data_out); else n_pass++;
        n_checks++; if (dut_if.done !== 1'b0) $display("FAIL rstmid_done got=%0b want=0", dut_if.done); else n_pass++;
        n_checks++; if (dut_if.parity_error !== 1'b0) $display("FAIL rstmid_parity_error got=%0b want=0", dut_if.parity_error); else n_pass++;
        n_checks++; if (dut_if.framing_error !== 1'b0) $display("FAIL rstmid_framing_error got=%0b want=0", dut_if.framing_error); else n_pass++;
        n_checks++; if (dut_if.busy !== 1'b0) $display("FAIL rstmid_busy got=%0b want=0", dut_if.busy); else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        dut_if.rx = 1'b1;
        repeat (40) @(negedge clk);
        n_checks++; if (done_cyc_q.size() != 0) $display("FAIL rstmid_spurious_done got=%0d want=0", done_cyc_q.size()); else n_pass++;
        clear_q();
        send_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, s);
        repeat (20) @(negedge clk);
        n_checks++; if (done_cyc_q.size() != 1) $display("FAIL recover_done_count got=%0d want=1", done_cyc_q.size()); else n_pass++;
        if (done_cyc_q.size() >= 1) begin
            n_checks++; if (data_q[0] !== 8'h81) $display("FAIL recover_data got=%02h want=81", data_q[0]); else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        int s0, s1;
        clear_q();
        send_frame(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, s0);
        send_frame(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, s1);
        repeat (20) @(negedge clk);
        n_checks++; if (done_cyc_q.size() != 2) $display("FAIL b2b_done_count got=%0d want=2", done_cyc_q.size()); else n_pass++;
        if (done_cyc_q.size() >= 2) begin
            n_checks++; if (done_cyc_q[1] - done_cyc_q[0] != 160) $display("FAIL b2b_spacing got=%0d want=160", done_cyc_q[1] - done_cyc_q[0]); else n_pass++;
            n_checks++; if (data_q[0] !== 8'h00) $display("FAIL b2b_data0 got=%02h want=00", data_q[0]); else n_pass++;
            n_checks++; if (data_q[1] !== 8'hFF) $display("FAIL b2b_data1 got=%02h want=ff", data_q[1]); else n_pass++;
            n_checks++; if (fe_q[0] !== 1'b0 || fe_q[1] !== 1'b0) $display("FAIL b2b_framing got=%0b%0b want=00", fe_q[0], fe_q[1]); else n_pass++;
        end
    endtask

    initial begin
        dut_if.rx = 1'b1;
        dut_if.parity_en = 1'b0;
        dut_if.odd_r_even_parity = 1'b0;
        @(negedge clk);
        test_reset();
        test_8n1();
        test_parity();
        test_framing();
        test_false_start();
        test_glitch();
        test_random();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/uart_rx_os16.md
# uart_rx_os16

16x-oversampling UART receiver. The peer transmitter sends each frame as:

- one start bit;
- DATA_WIDTH data bits, LSB first;
- an optional parity bit;
- one stop bit.

The block derives its own 16x sample tick from the system clock, synchronizes `rx`, validates the start bit and recovers the data word. It reports parity and framing status with a single-cycle `done` strobe. It sits on the receive side of the UART subsystem, opposite the transmitter, and uses the same parity controls.

## Interface

- `SYS_CLK`, 40000000: clock frequency in Hz.
- `BAUD_RATE`, 9600: line rate in bit/s.
- `DATA_WIDTH`, 8: data bits per frame, range 5..9.

Ports:

- `clk` in 1: single clock. Everything is on the rising edge.
- `rst` in 1: reset, synchronous, active-low.
- `rx` in 1: serial line, asynchronous, idle high.
- `parity_en` in 1: 1 = a parity bit follows the data.
- `odd_r_even_parity` in 1: 1 = odd parity, 0 = even parity.
- `data_out` out DATA_WIDTH: last received word.
- `done` out 1: one-cycle pulse when a frame completes.
- `parity_error` out 1: status of the last frame.
- `framing_error` out 1: status of the last frame.
- `busy` out 1: high while a frame is in progress.

## Operation

- **Tick generator.** DIV = SYS_CLK/(BAUD_RATE*16), integer floor, forced to at least 1. A counter runs 0..DIV-1, and `tick` is high for one cycle when it wraps.
- **Input synchronizer.** `rx` passes through a 2-flop synchronizer; its output is `rxs`. The register resets to 1.
- **Sample counter.** `sc` is 4 bits, advances on `tick`, and wraps 15→0. Each bit uses sample 8 as its mid-point.
- **Start arming.** Falling edge of `rxs` (previous 1, now 0) in IDLE: clear the tick and sample counters, then go to START.
- **IDLE:** wait for a falling edge on `rxs`.
- **START:** at sc=8, a sample of 0 moves to DATA. A sample of 1 is a false start and returns to IDLE with no `done`.
- **DATA:** at sc=8, shift the sample into the MSB of the shift register. After DATA_WIDTH bits, go to PARITY if `parity_en`, otherwise STOP.
- **PARITY:** at sc=8, check the sample.
  - Expected bit = XOR of the data bits, inverted when `odd_r_even_parity`=1.
  - A mismatch sets the internal parity flag.
- **STOP:** at sc=8, a sample of 0 sets the framing flag. In the same cycle:
  - load `data_out`, `parity_error` and `framing_error`;
  - pulse `done`;
  - return to IDLE.
- **Status outputs.** `data_out`, `parity_error` and `framing_error` hold until the next `done`. `parity_error` is 0 when `parity_en`=0.
- **`busy`.** High in START, DATA, PARITY and STOP; low in IDLE.
- **Break / stuck line.** If `rx` is stuck low after a framing error, no new frame is armed until `rxs` has returned to 1.
- **Mid-frame control changes.** `parity_en` and `odd_r_even_parity` are sampled at the start-bit validation (sc=8 in START). Changing them mid-frame has no effect on the current frame.
- **Reset.** `rst`=0 in any state goes to IDLE on the next edge and discards any partial frame.
- **Reset values:**
  - `data_out`=0, `done`=0, `parity_error`=0, `framing_error`=0, `busy`=0;
  - shift register and counters = 0;
  - synchronizer = 1.

## Timing

- Synchronizer latency: 2 clocks from `rx` to `rxs`.
- A bit period is 16 ticks, i.e. 16*DIV clocks.
- With DIV=1, the falling edge of `rx` registers at cycle t:
  - detection at t+2;
  - start sample at t+10;
  - `done` at t+10+16*(DATA_WIDTH+P+1), where P=`parity_en`. For 8N1 this is t+154.
- `done` is exactly one clock wide, and the outputs are valid in the same cycle.
- The next start is accepted from the first falling edge after return to IDLE, so back-to-back frames with a single stop bit are received.

## Configuration

- `UART_RX_MAJORITY_EN` defined: each bit value is the 2-of-3 majority of the samples at sc=6, 7 and 8. The decision is made at sc=8, so latency is unchanged.
- `UART_RX_MAJORITY_EN` undefined: single sample at sc=8.

## Test plan

- **8N1 frame.** SYS_CLK=1600000, BAUD_RATE=100000 (DIV=1), frame 0xA5 with stop=1.
  - Expect `data_out`=0xA5 and `done` at t+154.
  - Expect both error flags 0 and `busy` low one cycle after `done`.
- **Parity check.** `parity_en`=1, even parity, frame 0x5A.
  - Correct parity bit 0: `parity_error`=0.
  - Flipped parity bit: `parity_error`=1 and `data_out`=0x5A.
- **Framing error.** Frame 0x3C with stop driven 0: `framing_error`=1 and `done` pulses. Holding `rx` low afterwards produces no further `done`.
- **False start.** A 4-clock low glitch on `rx`: `busy` pulses briefly, with no `done` and no output change. With the macro defined, a 1-clock glitch at sc=7 of a data bit leaves 0xA5 intact.
- **Reset and recovery.** Assert `rst`=0 during the 4th data bit of a frame.
  - All outputs are 0 the next cycle.
  - A following frame 0x81 is received correctly.
- **Back-to-back.** Frames 0x00 and 0xFF with no idle gap: two `done` pulses 160 clocks apart, with correct data each time.
